ld_str_dispatch_queue: RTL and testbench

- In-order circular queue between dispatch and the single load/store reservation station in the Tomasulo LC-3b core.
- Buffers dispatched LDR/LDB/STR/STB ops and snoops the CDB to fill pending operands.
- Issues the head entry into the reservation station whenever that station is free, one op at a time, in program order.

---
 rtl/ld_str_dispatch_queue.sv | 150 +++++++++++++++
 tb/tb_ld_str_dispatch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_str_dispatch_queue.sv
// ld_str_dispatch_queue: in-order LD/ST queue between dispatch and the load/store reservation station.
// Optional LDSTQ_BYPASS_EN: a dispatch into an empty queue with a free station issues in the same cycle.
package lc3b_types;
    typedef enum logic [3:0] {
        op_br  = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
        op_jsr = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str = 4'h7,
        op_rti = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti = 4'hb,
        op_jmp = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
    } lc3b_opcode;
    typedef struct packed {
        logic        valid;
        logic [2:0]  tag;
        logic [15:0] data;
    } CDB;
endpackage

module ld_str_dispatch_queue
    import lc3b_types::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_we,
    output logic                      disp_ready,
    input  lc3b_opcode                disp_opcode,
    input  logic [DATA_WIDTH-1:0]     disp_Vbase,
    input  logic [DATA_WIDTH-1:0]     disp_Vsrc,
    input  logic [DATA_WIDTH-1:0]     disp_offset,
    input  logic                      disp_Vbase_valid,
    input  logic                      disp_Vsrc_valid,
    input  logic [TAG_WIDTH-1:0]      disp_Qbase,
    input  logic [TAG_WIDTH-1:0]      disp_Qsrc,
    input  logic [TAG_WIDTH-1:0]      disp_dest,
    input  CDB                        CDB_in,
    input  logic                      rs_done,
    output logic                      rs_WE,
    output lc3b_opcode                rs_opcode,
    output logic [DATA_WIDTH-1:0]     rs_Vbase,
    output logic [DATA_WIDTH-1:0]     rs_Vsrc,
    output logic [DATA_WIDTH-1:0]     rs_offset,
    output logic                      rs_Vbase_valid,
    output logic                      rs_Vsrc_valid,
    output logic [TAG_WIDTH-1:0]      rs_Qbase,
    output logic [TAG_WIDTH-1:0]      rs_Qsrc,
    output logic [TAG_WIDTH-1:0]      rs_dest,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        lc3b_opcode            opcode;
        logic [DATA_WIDTH-1:0] vbase;
        logic [DATA_WIDTH-1:0] vsrc;
        logic [DATA_WIDTH-1:0] offset;
        logic                  vbase_valid;
        logic                  vsrc_valid;
        logic [TAG_WIDTH-1:0]  qbase;
        logic [TAG_WIDTH-1:0]  qsrc;
        logic [TAG_WIDTH-1:0]  dest;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          rs_occupied;
    entry_t        disp_fwd;
    entry_t        head_fwd;
    entry_t        rs_e;
    logic          rs_free;
    logic          full;
    logic          issue_q;
    logic          bypass;
    logic          enq;

    // An operand still waiting on a tag picks up a matching broadcast; valid operands are never touched.
    function automatic entry_t snoop(entry_t e, CDB c);
        entry_t r = e;
        if (c.valid && !e.vbase_valid && e.qbase == c.tag) begin
            r.vbase       = c.data;
            r.vbase_valid = 1'b1;
        end
        if (c.valid && !e.vsrc_valid && e.qsrc == c.tag) begin
            r.vsrc       = c.data;
            r.vsrc_valid = 1'b1;
        end
        return r;
    endfunction

    always_comb begin
        disp_fwd = snoop('{disp_opcode, disp_Vbase, disp_Vsrc, disp_offset, disp_Vbase_valid,
                           disp_Vsrc_valid, disp_Qbase, disp_Qsrc, disp_dest}, CDB_in);
        head_fwd = snoop(mem[head], CDB_in);
    end

    assign full       = count == CW'(DEPTH);
    assign disp_ready = !full;
    assign rs_free    = !rs_occupied || rs_done;
    assign issue_q    = count != '0 && rs_free && !flush;
`ifdef LDSTQ_BYPASS_EN
    assign bypass     = count == '0 && disp_we && rs_free && !flush;
`else
    assign bypass     = 1'b0;
`endif
    assign enq        = disp_we && !full && !flush && !bypass;
    assign rs_WE      = issue_q || bypass;
    assign rs_e       = bypass ? disp_fwd : head_fwd;

    assign rs_opcode      = rs_e.opcode;
    assign rs_Vbase       = rs_e.vbase;
    assign rs_Vsrc        = rs_e.vsrc;
    assign rs_offset      = rs_e.offset;
    assign rs_Vbase_valid = rs_e.vbase_valid;
    assign rs_Vsrc_valid  = rs_e.vsrc_valid;
    assign rs_Qbase       = rs_e.qbase;
    assign rs_Qsrc        = rs_e.qsrc;
    assign rs_dest        = rs_e.dest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rs_occupied <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rs_occupied <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].vbase_valid <= 1'b0;
                mem[i].vsrc_valid  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= snoop(mem[i], CDB_in);
            if (enq) begin
                mem[tail] <= disp_fwd;
                tail      <= tail + PW'(1);
            end
            if (issue_q) head <= head + PW'(1);
            count       <= count + CW'(enq) - CW'(issue_q);
            rs_occupied <= rs_WE || (rs_occupied && !rs_done);
        end
    end
endmodule

// File: tb/tb_ld_str_dispatch_queue.sv
// tb_ld_str_dispatch_queue: directed vector table, corner sequences and random traffic against a queue model.
module tb_ld_str_dispatch_queue;
    import lc3b_types::*;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        disp_we = 1'b0;
    logic        disp_ready;
    lc3b_opcode  disp_opcode = op_ldr;
    logic [15:0] disp_Vbase = '0, disp_Vsrc = '0, disp_offset = '0;
    logic        disp_Vbase_valid = 1'b0, disp_Vsrc_valid = 1'b0;
    logic [2:0]  disp_Qbase = '0, disp_Qsrc = '0, disp_dest = '0;
    CDB          CDB_in = '0;
    logic        rs_done = 1'b0;
    logic        rs_WE;
    lc3b_opcode  rs_opcode;
    logic [15:0] rs_Vbase, rs_Vsrc, rs_offset;
    logic        rs_Vbase_valid, rs_Vsrc_valid;
    logic [2:0]  rs_Qbase, rs_Qsrc, rs_dest;
    logic [2:0]  count;
    int          tests = 0;
    int          fails = 0;

    ld_str_dispatch_queue #(.DATA_WIDTH(16), .TAG_WIDTH(3), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .disp_we(disp_we), .disp_ready(disp_ready),
        .disp_opcode(disp_opcode), .disp_Vbase(disp_Vbase), .disp_Vsrc(disp_Vsrc),
        .disp_offset(disp_offset), .disp_Vbase_valid(disp_Vbase_valid),
        .disp_Vsrc_valid(disp_Vsrc_valid), .disp_Qbase(disp_Qbase), .disp_Qsrc(disp_Qsrc),
        .disp_dest(disp_dest), .CDB_in(CDB_in), .rs_done(rs_done), .rs_WE(rs_WE),
        .rs_opcode(rs_opcode), .rs_Vbase(rs_Vbase), .rs_Vsrc(rs_Vsrc), .rs_offset(rs_offset),
        .rs_Vbase_valid(rs_Vbase_valid), .rs_Vsrc_valid(rs_Vsrc_valid), .rs_Qbase(rs_Qbase),
        .rs_Qsrc(rs_Qsrc), .rs_dest(rs_dest), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        lc3b_opcode  op;
        logic [15:0] vb, vs, off;
        logic        vbv, vsv;
        logic [2:0]  qb, qs, dest;
    } ent_t;

    typedef struct {
        bit we; lc3b_opcode op; bit [2:0] dest, qb; bit vbv; bit [2:0] qs; bit vsv;
        bit done, cv; bit [2:0] ct; bit [15:0] cd;
        bit ewe; int ecnt; bit erdy; bit [2:0] edest; int sel; bit [15:0] eval;
    } vec_t;

    ent_t mq[$];
    bit   m_occ = 1'b0;

    function automatic ent_t fwd(ent_t e, CDB c);
        ent_t r = e;
        if (c.valid && !r.vbv && r.qb == c.tag) begin r.vb = c.data; r.vbv = 1'b1; end
        if (c.valid && !r.vsv && r.qs == c.tag) begin r.vs = c.data; r.vsv = 1'b1; end
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks this cycle's outputs against the model, advances the model, then waits for the next negedge.
    task automatic cyc();
        ent_t d, e;
        bit free, byp, iss, acc;
        #1;
        d = fwd('{disp_opcode, disp_Vbase, disp_Vsrc, disp_offset, disp_Vbase_valid, disp_Vsrc_valid,
                  disp_Qbase, disp_Qsrc, disp_dest}, CDB_in);
        free = !m_occ || rs_done;
        byp = 1'b0;
`ifdef LDSTQ_BYPASS_EN
        byp = mq.size() == 0 && disp_we && free && !flush;
`endif
        iss = mq.size() > 0 && free && !flush;
        e = d;
        if (iss) e = fwd(mq[0], CDB_in);
        chk("count", int'(count), mq.size());
        chk("disp_ready", int'(disp_ready), int'(mq.size() < DEPTH));
        chk("rs_WE", int'(rs_WE), int'(byp || iss));
        if (byp || iss) begin
            chk("rs_opcode", int'(rs_opcode), int'(e.op));
            chk("rs_Vbase", int'(rs_Vbase), int'(e.vb));
            chk("rs_Vsrc", int'(rs_Vsrc), int'(e.vs));
            chk("rs_offset", int'(rs_offset), int'(e.off));
            chk("rs_Vbase_valid", int'(rs_Vbase_valid), int'(e.vbv));
            chk("rs_Vsrc_valid", int'(rs_Vsrc_valid), int'(e.vsv));
            chk("rs_Qbase", int'(rs_Qbase), int'(e.qb));
            chk("rs_Qsrc", int'(rs_Qsrc), int'(e.qs));
            chk("rs_dest", int'(rs_dest), int'(e.dest));
        end
        acc = disp_we && mq.size() < DEPTH && !byp && !flush;
        if (flush) begin
            mq.delete();
            m_occ = 1'b0;
        end else begin
            foreach (mq[i]) mq[i] = fwd(mq[i], CDB_in);
            if (iss) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            m_occ = (byp || iss) ? 1'b1 : (rs_done ? 1'b0 : m_occ);
        end
        @(negedge clk);
    endtask

    task automatic drive(bit we, lc3b_opcode op, bit [2:0] dest, bit [2:0] qb, bit vbv,
                         bit [2:0] qs, bit vsv, bit done, bit cv, bit [2:0] ct, bit [15:0] cd);
        disp_we = we; disp_opcode = op; disp_dest = dest;
        disp_Qbase = qb; disp_Vbase_valid = vbv; disp_Vbase = vbv ? 16'h0100 + 16'(dest) : 16'h0;
        disp_Qsrc = qs; disp_Vsrc_valid = vsv; disp_Vsrc = vsv ? 16'h0200 + 16'(dest) : 16'h0;
        disp_offset = 16'(dest);
        rs_done = done; CDB_in = '{cv, ct, cd};
    endtask

    vec_t vecs[19];
    lc3b_opcode ops[4] = '{op_ldr, op_ldb, op_str, op_stb};

    initial begin
        //          we op     d  qb vbv qs vsv dn cv ct cd        ewe cnt rdy edst sel eval
        vecs[0]  = '{1, op_ldr, 1, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0};
        vecs[1]  = '{1, op_ldr, 2, 0, 1, 0, 1, 0, 0, 0, 16'h0,    1, 1, 1, 1, 0, 16'h0};
        vecs[2]  = '{1, op_ldr, 3, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0};
        vecs[3]  = '{1, op_ldr, 4, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 2, 1, 0, 0, 16'h0};
        vecs[4]  = '{1, op_ldr, 5, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 3, 1, 0, 0, 16'h0};
        vecs[5]  = '{1, op_ldr, 6, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 4, 0, 0, 0, 16'h0};
        vecs[6]  = '{0, op_ldr, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 4, 0, 0, 0, 16'h0};
        vecs[7]  = '{0, op_ldr, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0,    1, 4, 0, 2, 0, 16'h0};
        vecs[8]  = '{0, op_ldr, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0,    1, 3, 1, 3, 0, 16'h0};
        vecs[9]  = '{1, op_ldr, 7, 0, 1, 0, 1, 1, 0, 0, 16'h0,    1, 2, 1, 4, 0, 16'h0};
        vecs[10] = '{0, op_ldr, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 2, 1, 0, 0, 16'h0};
        vecs[11] = '{0, op_ldr, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0,    1, 2, 1, 5, 0, 16'h0};
        vecs[12] = '{1, op_str, 0, 0, 1, 5, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 16'h0};
        vecs[13] = '{0, op_ldr, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 2, 1, 0, 0, 16'h0};
        vecs[14] = '{0, op_ldr, 0, 0, 1, 0, 1, 0, 1, 5, 16'h1234, 0, 2, 1, 0, 0, 16'h0};
        vecs[15] = '{0, op_ldr, 0, 0, 1, 0, 1, 1, 0, 0, 16'h0,    1, 2, 1, 7, 0, 16'h0};
        vecs[16] = '{1, op_ldb, 3, 2, 0, 0, 1, 1, 0, 0, 16'h0,    1, 1, 1, 0, 1, 16'h1234};
        vecs[17] = '{0, op_ldr, 0, 0, 1, 0, 1, 1, 1, 2, 16'h0040, 1, 1, 1, 3, 2, 16'h0040};
        vecs[18] = '{0, op_ldr, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0,    0, 0, 1, 0, 0, 16'h0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_rs_WE", int'(rs_WE), 0);
        chk("reset_ready", int'(disp_ready), 1);
        chk("reset_rs_dest", int'(rs_dest), 0);
        chk("reset_rs_Vbase", int'(rs_Vbase), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].op, vecs[i].dest, vecs[i].qb, vecs[i].vbv, vecs[i].qs,
                  vecs[i].vsv, vecs[i].done, vecs[i].cv, vecs[i].ct, vecs[i].cd);
`ifndef LDSTQ_BYPASS_EN
            #1;
            chk($sformatf("vec%0d_we", i), int'(rs_WE), int'(vecs[i].ewe));
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].ecnt);
            chk($sformatf("vec%0d_ready", i), int'(disp_ready), int'(vecs[i].erdy));
            if (vecs[i].ewe) chk($sformatf("vec%0d_dest", i), int'(rs_dest), int'(vecs[i].edest));
            if (vecs[i].sel == 1) begin
                chk($sformatf("vec%0d_Vsrc", i), int'(rs_Vsrc), int'(vecs[i].eval));
                chk($sformatf("vec%0d_Vsrc_valid", i), int'(rs_Vsrc_valid), 1);
            end
            if (vecs[i].sel == 2) begin
                chk($sformatf("vec%0d_Vbase", i), int'(rs_Vbase), int'(vecs[i].eval));
                chk($sformatf("vec%0d_Vbase_valid", i), int'(rs_Vbase_valid), 1);
            end
`endif
            cyc();
        end

        // Six back-to-back enqueue/issue pairs walk the pointers past DEPTH-1.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i % 4], 3'(i + 1), 3'(i), 1'b1, 3'(i), 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
            cyc();
        end
        drive(1'b0, op_ldr, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, op_ldr, 3'(i + 1), 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            cyc();
        end
        drive(1'b1, op_str, 3'd6, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        flush = 1'b1;
        #1;
        chk("flush_rs_WE", int'(rs_WE), 0);
        cyc();
        flush = 1'b0;
        drive(1'b0, op_ldr, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
        chk("flush_count", int'(count), 0);
        chk("flush_ready", int'(disp_ready), 1);
        cyc();

        drive(1'b1, op_stb, 3'd3, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
`ifdef LDSTQ_BYPASS_EN
        chk("bypass_we", int'(rs_WE), 1);
        chk("bypass_offset", int'(rs_offset), 16'h0003);
        cyc();
        disp_we = 1'b0;
        #1;
        chk("bypass_count", int'(count), 0);
        cyc();
`else
        chk("nobypass_we0", int'(rs_WE), 0);
        cyc();
        disp_we = 1'b0;
        #1;
        chk("nobypass_count", int'(count), 1);
        chk("nobypass_we1", int'(rs_WE), 1);
        chk("nobypass_offset", int'(rs_offset), 16'h0003);
        cyc();
`endif

        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 6, ops[$urandom_range(0, 3)], 3'($urandom), 3'($urandom),
                  1'($urandom), 3'($urandom), 1'($urandom), $urandom_range(0, 9) < 4,
                  1'($urandom), 3'($urandom), 16'($urandom));
            flush = $urandom_range(0, 99) < 3;
            cyc();
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, op_ldr, 3'(i + 1), 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            cyc();
        end
        drive(1'b0, op_ldr, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0);
        #1;
        chk("pre_reset_count", int'(count), 3);
        rst_n = 1'b0;
        #1;
        chk("midreset_count", int'(count), 0);
        chk("midreset_rs_WE", int'(rs_WE), 0);
        mq.delete();
        m_occ = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postreset_ready", int'(disp_ready), 1);
        cyc();
        drive(1'b1, op_stb, 3'd2, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        cyc();
        disp_we = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
